pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Sequences the six PWM channel controllers through bring-up and duty ramping.
- Each PWM control register exposes enable, reset, increase-duty and decrease-duty strobes; this block drives those strobes for every channel.
- Channels are walked one at a time in ascending index order, so supply-load steps never coincide.
- Sits between the register bank (start/target inputs) and the PWM channel controllers (strobe outputs).

Parameters:
- N_CH, 6, number of PWM channels sequenced
- LVL_W, 4, width of a duty-level count (levels 0..2^LVL_W-1)
- GAP_W, 16, width of the inter-step gap counter
- RST_CYCLES, 2, cycles pwm_rst is held per channel during init

Ports:
- clk_axi  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a sequence
- abort  in  1  level; forces all channels off and returns to IDLE
- ch_mask  in  N_CH  channels included in the run
- target_lvl  in  N_CH*LVL_W  per-channel target duty level; channel i uses bits [i*LVL_W +: LVL_W]
- step_gap  in  GAP_W  clk_axi cycles between successive inc/dec strobes
- pwm_en  out  N_CH  per-channel PWM enable (level)
- pwm_rst  out  N_CH  per-channel PWM reset strobe
- duty_inc  out  N_CH  one-cycle increase-duty strobe
- duty_dec  out  N_CH  one-cycle decrease-duty strobe
- cur_lvl  out  N_CH*LVL_W  tracked duty level per channel
- active_ch  out  3  index of the channel being serviced
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset state: all outputs 0; cur_lvl all 0; FSM in IDLE.
- All outputs are registered.
- Latched inputs:
  - In IDLE, start=1 latches ch_mask, target_lvl and step_gap.
  - Input changes during a run are ignored.
  - start while busy is ignored.
- FSM states: IDLE, SEL, INIT, STEP, WAIT, DONE.
- IDLE:
  - start accepted at edge n -> SEL; busy=1 from n+1.
- SEL:
  - Selects the lowest set, unserviced mask bit and sets active_ch to it.
  - No remaining bits -> DONE.
  - Mask of 0 -> DONE, so done pulses 2 cycles after start.
- INIT (only when pwm_en[ch]=0):
  - pwm_en[ch] is set and stays 1.
  - pwm_rst[ch]=1 for exactly RST_CYCLES cycles.
  - cur_lvl[ch] is cleared to 0, then -> STEP.
  - A channel already enabled skips INIT and goes SEL -> STEP (retarget without reset).
- STEP:
  - cur==target -> mark serviced, -> SEL.
  - cur<target -> duty_inc[ch]=1 for one cycle, cur+1, -> WAIT.
  - cur>target -> duty_dec[ch]=1 for one cycle, cur-1, -> WAIT.
- WAIT:
  - Counts max(step_gap,1) cycles, then -> STEP.
  - Strobes on one channel are therefore spaced step_gap+1 cycles apart (step_gap=0 behaves as 1).
- DONE:
  - done=1 for one cycle, busy=0, -> IDLE.
  - pwm_en and cur_lvl are retained.
- Strobe exclusivity:
  - At most one of duty_inc/duty_dec/pwm_rst is high in any cycle, on at most one channel.
- cur_lvl arithmetic:
  - Never wraps; it moves only toward target, and target is within range by width.
- abort (any state, including IDLE):
  - Next edge: IDLE, pwm_en=0, all strobes 0, cur_lvl=0, busy=0, no done.
  - abort and start together: abort wins, start is dropped.
- rst mid-run:
  - Immediate return to reset values; a strobe is never left high.

Decomposition:
- Shared package pwm_seq_pkg holds:
  - FSM state enum
  - N_CH and LVL_W defaults
  - field offsets of the PWM control register: clk div [2:0], duty div [5:3], dec 6, inc 7, reset 8, enable 9
  - first PWM register index (14)
- Sub-module pwm_gap_timer: loadable down-counter with load/expire, used by WAIT. Everything else stays in one module.

Test Plan:
- Mask 6'b000001, target0=3, gap=4, channel off:
  - pwm_rst[0] high for 2 cycles, then 3 duty_inc[0] pulses spaced 5 cycles apart.
  - cur_lvl0=3, then done pulse, busy low.
- Mask 6'b100101, targets ch0=1, ch2=2, ch5=0:
  - Channels serviced in order 0, 2, 5 (check active_ch).
  - ch5 gets reset but no inc.
  - pwm_en=6'b100101 at done.
- Retarget: after the first test (ch0=3), start with target0=1:
  - No pwm_rst; 2 duty_dec[0] pulses; cur_lvl0=1.
- Abort during WAIT of the second inc:
  - Next cycle pwm_en=0, cur_lvl=0, busy=0, done never pulses.
- Mask 0 and start+abort:
  - Mask 0: done 2 cycles after start.
  - Simultaneous start+abort in IDLE: stays IDLE, busy stays 0.
- Async rst asserted mid-strobe, off-edge:
  - All outputs 0 immediately.
  - A start after rst release runs normally from INIT.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// ============================================================================
// Module   : pwm_seq_pkg
// Brief    : Shared types and constants for the PWM ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_seq_pkg;

  localparam int N_CH_DEF  = 6;
  localparam int LVL_W_DEF = 4;

  // PWM control register layout as seen by the channel controllers
  localparam int PWM_REG_FIRST      = 14;
  localparam int PWM_F_CLKDIV_LSB   = 0;
  localparam int PWM_F_CLKDIV_MSB   = 2;
  localparam int PWM_F_DUTYDIV_LSB  = 3;
  localparam int PWM_F_DUTYDIV_MSB  = 5;
  localparam int PWM_F_DEC          = 6;
  localparam int PWM_F_INC          = 7;
  localparam int PWM_F_RESET        = 8;
  localparam int PWM_F_ENABLE       = 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_INIT = 3'd2,
    S_STEP = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_ramp_sequencer_if.sv
// ============================================================================
// Module   : pwm_ramp_sequencer_if
// Brief    : Register-bank / PWM-strobe bundle of the ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_ramp_sequencer_if #(
  parameter int N_CH  = pwm_seq_pkg::N_CH_DEF,
  parameter int LVL_W = pwm_seq_pkg::LVL_W_DEF,
  parameter int GAP_W = 16
) ();

  logic                    start;
  logic                    abort;
  logic [N_CH-1:0]         ch_mask;
  logic [N_CH*LVL_W-1:0]   target_lvl;
  logic [GAP_W-1:0]        step_gap;

  logic [N_CH-1:0]         pwm_en;
  logic [N_CH-1:0]         pwm_rst;
  logic [N_CH-1:0]         duty_inc;
  logic [N_CH-1:0]         duty_dec;
  logic [N_CH*LVL_W-1:0]   cur_lvl;
  logic [2:0]              active_ch;
  logic                    busy;
  logic                    done;

  modport master (
    output start, abort, ch_mask, target_lvl, step_gap,
    input  pwm_en, pwm_rst, duty_inc, duty_dec, cur_lvl, active_ch, busy, done
  );

  modport slave (
    input  start, abort, ch_mask, target_lvl, step_gap,
    output pwm_en, pwm_rst, duty_inc, duty_dec, cur_lvl, active_ch, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/pwm_gap_timer.sv
// ============================================================================
// Module   : pwm_gap_timer
// Brief    : Loadable down-counter; o_expired is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk_axi,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
// ============================================================================
// Module   : pwm_ramp_sequencer
// Brief    : Walks enabled PWM channels in index order, resetting and ramping duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int LVL_W      = LVL_W_DEF,
  parameter int GAP_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk_axi,
  input  logic                 rst,
  pwm_ramp_sequencer_if.slave  bus
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  seq_state_t              r_state, w_state_nx;
  logic [N_CH-1:0]         r_pending, w_pending_nx;
  logic [N_CH*LVL_W-1:0]   r_target, w_target_nx;
  logic [GAP_W-1:0]        r_gap, w_gap_nx;
  logic [N_CH-1:0]         r_pwm_en, w_pwm_en_nx;
  logic [N_CH-1:0]         r_pwm_rst, w_pwm_rst_nx;
  logic [N_CH-1:0]         r_inc, w_inc_nx;
  logic [N_CH-1:0]         r_dec, w_dec_nx;
  logic [N_CH*LVL_W-1:0]   r_cur, w_cur_nx;
  logic [2:0]              r_active, w_active_nx;
  logic                    r_busy, w_busy_nx;
  logic                    r_done, w_done_nx;
  logic [RCW-1:0]          r_rcnt, w_rcnt_nx;

  logic                    w_found;
  logic [2:0]              w_sel;
  logic [LVL_W-1:0]        w_cur_lvl;
  logic [LVL_W-1:0]        w_tgt_lvl;
  logic                    w_tmr_load;
  logic [GAP_W-1:0]        w_tmr_val;
  logic                    w_tmr_expired;

  pwm_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk_axi   (clk_axi),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_val     (w_tmr_val),
    .o_expired (w_tmr_expired)
  );

  // Lowest pending channel wins, giving ascending service order
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found = 1'b1;
        w_sel   = 3'(i);
      end
    end
  end

  assign w_cur_lvl = r_cur[int'(r_active)*LVL_W +: LVL_W];
  assign w_tgt_lvl = r_target[int'(r_active)*LVL_W +: LVL_W];
  // A zero gap is treated as one so strobes are never back to back
  assign w_tmr_val = (r_gap == '0) ? '0 : r_gap - 1'b1;

  always_comb begin
    w_state_nx   = r_state;
    w_pending_nx = r_pending;
    w_target_nx  = r_target;
    w_gap_nx     = r_gap;
    w_pwm_en_nx  = r_pwm_en;
    w_cur_nx     = r_cur;
    w_active_nx  = r_active;
    w_busy_nx    = r_busy;
    w_rcnt_nx    = r_rcnt;
    w_pwm_rst_nx = '0;
    w_inc_nx     = '0;
    w_dec_nx     = '0;
    w_done_nx    = 1'b0;
    w_tmr_load   = 1'b0;

    if (bus.abort) begin
      w_state_nx   = S_IDLE;
      w_pending_nx = '0;
      w_pwm_en_nx  = '0;
      w_cur_nx     = '0;
      w_active_nx  = '0;
      w_busy_nx    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_pending_nx = bus.ch_mask;
            w_target_nx  = bus.target_lvl;
            w_gap_nx     = bus.step_gap;
            w_busy_nx    = 1'b1;
            w_state_nx   = S_SEL;
          end
        end
        S_SEL: begin
          if (!w_found) begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = S_DONE;
          end else begin
            w_active_nx = w_sel;
            if (!r_pwm_en[w_sel]) begin
              w_pwm_en_nx[w_sel]                     = 1'b1;
              w_pwm_rst_nx[w_sel]                    = 1'b1;
              w_cur_nx[int'(w_sel)*LVL_W +: LVL_W]   = '0;
              w_rcnt_nx                              = RCW'(RST_CYCLES - 1);
              w_state_nx                             = S_INIT;
            end else begin
              w_state_nx = S_STEP;
            end
          end
        end
        S_INIT: begin
          if (r_rcnt == '0) begin
            w_state_nx = S_STEP;
          end else begin
            w_rcnt_nx              = r_rcnt - 1'b1;
            w_pwm_rst_nx[r_active] = 1'b1;
          end
        end
        S_STEP: begin
          if (w_cur_lvl == w_tgt_lvl) begin
            w_pending_nx[r_active] = 1'b0;
            w_state_nx             = S_SEL;
          end else if (w_cur_lvl < w_tgt_lvl) begin
            w_inc_nx[r_active]                        = 1'b1;
            w_cur_nx[int'(r_active)*LVL_W +: LVL_W]   = w_cur_lvl + LVL_W'(1);
            w_tmr_load                                = 1'b1;
            w_state_nx                                = S_WAIT;
          end else begin
            w_dec_nx[r_active]                        = 1'b1;
            w_cur_nx[int'(r_active)*LVL_W +: LVL_W]   = w_cur_lvl - LVL_W'(1);
            w_tmr_load                                = 1'b1;
            w_state_nx                                = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_tmr_expired) begin
            w_state_nx = S_STEP;
          end
        end
        S_DONE: begin
          w_state_nx = S_IDLE;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_axi or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_target  <= '0;
      r_gap     <= '0;
      r_pwm_en  <= '0;
      r_pwm_rst <= '0;
      r_inc     <= '0;
      r_dec     <= '0;
      r_cur     <= '0;
      r_active  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rcnt    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      r_target  <= w_target_nx;
      r_gap     <= w_gap_nx;
      r_pwm_en  <= w_pwm_en_nx;
      r_pwm_rst <= w_pwm_rst_nx;
      r_inc     <= w_inc_nx;
      r_dec     <= w_dec_nx;
      r_cur     <= w_cur_nx;
      r_active  <= w_active_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_rcnt    <= w_rcnt_nx;
    end
  end

  assign bus.pwm_en    = r_pwm_en;
  assign bus.pwm_rst   = r_pwm_rst;
  assign bus.duty_inc  = r_inc;
  assign bus.duty_dec  = r_dec;
  assign bus.cur_lvl   = r_cur;
  assign bus.active_ch = r_active;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
// ============================================================================
// Module   : tb_pwm_ramp_sequencer
// Brief    : Self-checking bench; strobe events are compared to a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_sequencer;

  localparam int NC = 6;
  localparam int LW = 4;
  localparam int GW = 16;
  localparam int RC = 2;

  localparam int K_RST  = 0;
  localparam int K_INC  = 1;
  localparam int K_DEC  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int t;
    int kind;
    int ch;
    int act;
  } ev_t;

  logic clk_axi = 1'b0;
  logic rst     = 1'b1;

  pwm_ramp_sequencer_if #(.N_CH(NC), .LVL_W(LW), .GAP_W(GW)) bus ();

  pwm_ramp_sequencer #(
    .N_CH(NC), .LVL_W(LW), .GAP_W(GW), .RST_CYCLES(RC)
  ) dut (
    .clk_axi (clk_axi),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_axi = ~clk_axi;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit mon_on   = 1'b0;
  bit done_seen = 1'b0;
  int excl_err = 0;
  int busy_err = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int m_en[NC];
  int m_cur[NC];

  always @(posedge clk_axi) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int t, input int kind, input int ch, input int act);
    ev_t e;
    e.t = t; e.kind = kind; e.ch = ch; e.act = act;
    return e;
  endfunction

  function automatic logic [31:0] pack_ev(input ev_t e);
    return {e.t[19:0], e.kind[3:0], e.ch[3:0], e.act[3:0]};
  endfunction

  // Event monitor: one record per asserted strobe bit per cycle
  always @(negedge clk_axi) begin
    if (mon_on) begin
      for (int i = 0; i < NC; i++) begin
        if (bus.pwm_rst[i])  obs_q.push_back(mk_ev(cyc - t0, K_RST, i, int'(bus.active_ch)));
        if (bus.duty_inc[i]) obs_q.push_back(mk_ev(cyc - t0, K_INC, i, int'(bus.active_ch)));
        if (bus.duty_dec[i]) obs_q.push_back(mk_ev(cyc - t0, K_DEC, i, int'(bus.active_ch)));
      end
      if (bus.done) begin
        obs_q.push_back(mk_ev(cyc - t0, K_DONE, 0, 0));
        done_seen = 1'b1;
        if (bus.busy) busy_err++;
      end
      if ($countones({bus.pwm_rst, bus.duty_inc, bus.duty_dec}) > 1) excl_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_en[c]  = 0;
      m_cur[c] = 0;
    end
  endtask

  function automatic logic [NC*LW-1:0] exp_cur();
    logic [NC*LW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*LW +: LW] = LW'(m_cur[c]);
    return v;
  endfunction

  function automatic logic [NC-1:0] exp_en();
    logic [NC-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c] = (m_en[c] != 0);
    return v;
  endfunction

  // Timeline model, times relative to the edge that accepts start
  task automatic model_run(input logic [NC-1:0] m, input logic [NC*LW-1:0] tg,
                           input logic [GW-1:0] gp, output int tend);
    int t, g, first, d, kind, tv;
    g = (gp == '0) ? 1 : int'(gp);
    t = 1;
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      if (m[c]) begin
        tv = int'(tg[c*LW +: LW]);
        if (m_en[c] == 0) begin
          for (int r = 0; r < RC; r++) exp_q.push_back(mk_ev(t + r, K_RST, c, c));
          first    = t + RC + 1;
          m_en[c]  = 1;
          m_cur[c] = 0;
        end else begin
          first = t + 1;
        end
        if (tv >= m_cur[c]) begin d = tv - m_cur[c]; kind = K_INC; end
        else begin d = m_cur[c] - tv; kind = K_DEC; end
        for (int k = 0; k < d; k++) exp_q.push_back(mk_ev(first + k * (g + 1), kind, c, c));
        m_cur[c] = tv;
        t = first + d * (g + 1) + 1;
      end
    end
    exp_q.push_back(mk_ev(t, K_DONE, 0, 0));
    tend = t;
  endtask

  task automatic run(input logic [NC-1:0] m, input logic [NC*LW-1:0] tg,
                     input logic [GW-1:0] gp, input bit poke, input string tag);
    int tend, n;
    model_run(m, tg, gp, tend);
    @(negedge clk_axi);
    obs_q.delete();
    done_seen = 1'b0; excl_err = 0; busy_err = 0;
    bus.ch_mask = m; bus.target_lvl = tg; bus.step_gap = gp; bus.start = 1'b1;
    t0 = cyc + 1;
    mon_on = 1'b1;
    @(negedge clk_axi);
    bus.start      = 1'b0;
    bus.ch_mask    = NC'($urandom);
    bus.target_lvl = (NC*LW)'($urandom);
    bus.step_gap   = GW'($urandom_range(0, 7));
    chk({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!done_seen && n < tend + 20) begin
      @(negedge clk_axi);
      n++;
      bus.start = (poke && tend > 8 && n == 3);
    end
    bus.start = 1'b0;
    chk({tag, ".done_seen"}, 32'(done_seen), 32'd1);
    @(negedge clk_axi);
    @(negedge clk_axi);
    mon_on = 1'b0;
    chk({tag, ".n_events"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s.ev%0d", tag, i), pack_ev(obs_q[i]), pack_ev(exp_q[i]));
    chk({tag, ".pwm_en"},  32'(bus.pwm_en),  32'(exp_en()));
    chk({tag, ".cur_lvl"}, 32'(bus.cur_lvl), 32'(exp_cur()));
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, ".excl"}, 32'(excl_err), 32'd0);
    chk({tag, ".busy_at_done"}, 32'(busy_err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, incs;
    logic [NC-1:0]    rm;
    logic [NC*LW-1:0] rt;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.ch_mask = '0; bus.target_lvl = '0; bus.step_gap = '0;
    model_clear();

    // Reset values
    repeat (3) @(negedge clk_axi);
    chk("rst.pwm_en",    32'(bus.pwm_en),    32'd0);
    chk("rst.pwm_rst",   32'(bus.pwm_rst),   32'd0);
    chk("rst.duty_inc",  32'(bus.duty_inc),  32'd0);
    chk("rst.duty_dec",  32'(bus.duty_dec),  32'd0);
    chk("rst.cur_lvl",   32'(bus.cur_lvl),   32'd0);
    chk("rst.active_ch", 32'(bus.active_ch), 32'd0);
    chk("rst.busy",      32'(bus.busy),      32'd0);
    chk("rst.done",      32'(bus.done),      32'd0);
    rst = 1'b0;

    run(6'b000001, 24'h000003, 16'd4, 1'b0, "ch0_up3");
    run(6'b000001, 24'h000001, 16'd4, 1'b0, "ch0_retarget1");
    run(6'b100101, 24'h000201, 16'd2, 1'b1, "mask_100101");
    run(6'b000010, 24'h000020, 16'd0, 1'b0, "gap0");
    for (int k = 0; k < 4; k++) begin
      rm = NC'($urandom);
      rt = (NC*LW)'($urandom);
      run(rm, rt, GW'($urandom_range(0, 3)), 1'b1, $sformatf("rand%0d", k));
    end
    run(6'b000000, 24'h000000, 16'd4, 1'b0, "mask0");

    // Abort in IDLE clears retained state
    @(negedge clk_axi); bus.abort = 1'b1;
    @(negedge clk_axi); bus.abort = 1'b0;
    model_clear();
    chk("abort_idle.pwm_en",  32'(bus.pwm_en),  32'd0);
    chk("abort_idle.cur_lvl", 32'(bus.cur_lvl), 32'd0);

    // Abort during the wait after the second increment
    bus.ch_mask = 6'b000001; bus.target_lvl = 24'h000003; bus.step_gap = 16'd4;
    bus.start = 1'b1; done_seen = 1'b0; mon_on = 1'b1; t0 = cyc + 1;
    @(negedge clk_axi); bus.start = 1'b0;
    n = 0; incs = 0;
    while (incs < 2 && n < 100) begin
      @(negedge clk_axi); n++;
      if (bus.duty_inc[0]) incs++;
    end
    chk("abort.second_inc", 32'(incs), 32'd2);
    @(negedge clk_axi);
    bus.abort = 1'b1;
    @(negedge clk_axi);
    bus.abort = 1'b0;
    chk("abort.pwm_en",  32'(bus.pwm_en),  32'd0);
    chk("abort.cur_lvl", 32'(bus.cur_lvl), 32'd0);
    chk("abort.busy",    32'(bus.busy),    32'd0);
    repeat (40) @(negedge clk_axi);
    chk("abort.no_done", 32'(done_seen), 32'd0);

    // Start and abort together in IDLE: start is dropped
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk_axi);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort.busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk_axi);
    chk("start_abort.busy_later", 32'(bus.busy), 32'd0);
    chk("start_abort.no_done", 32'(done_seen), 32'd0);
    mon_on = 1'b0;

    // Asynchronous reset while a strobe is high
    bus.start = 1'b1;
    @(negedge clk_axi); bus.start = 1'b0;
    n = 0;
    while (!bus.duty_inc[0] && n < 100) begin
      @(negedge clk_axi); n++;
    end
    chk("arst.inc_seen", 32'(bus.duty_inc[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.duty_inc", 32'(bus.duty_inc), 32'd0);
    chk("arst.pwm_en",   32'(bus.pwm_en),   32'd0);
    chk("arst.cur_lvl",  32'(bus.cur_lvl),  32'd0);
    chk("arst.busy",     32'(bus.busy),     32'd0);
    @(negedge clk_axi); rst = 1'b0;
    model_clear();
    run(6'b000001, 24'h000002, 16'd1, 1'b0, "after_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
